// File: rtl/ctrl_issue_sequencer.sv
// ctrl_issue_sequencer: FIFO-buffered issue of 7-bit control words to the decoder, with hold-off after multi-cycle words
module ctrl_issue_sequencer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [6:0]                 in_word,
  input  logic                       flush,
  output logic                       dec_valid,
  output logic [6:0]                 dec_word,
  input  logic                       dec_ack,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [CNT_W-1:0]           issued_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int HW = $clog2(HOLD_CYCLES+1);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t state, state_nxt;
  logic [6:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [HW-1:0] hold;
  logic push, pop, multi, not_empty;
  assign not_empty = fifo_count != '0;
  assign in_ready = !rst && !flush && (fifo_count < CW'(DEPTH));
  assign push = in_valid && in_ready;
  assign dec_valid = state == ISSUE;
  assign multi = dec_word[3] && dec_word[4];
  assign busy = state != IDLE || not_empty;
  always_comb begin
    state_nxt = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = not_empty;
        state_nxt = not_empty ? ISSUE : IDLE;
      end
      ISSUE: if (dec_ack) begin
        pop = !multi && not_empty;
        state_nxt = multi ? HOLD : (not_empty ? ISSUE : IDLE);
      end
      HOLD: state_nxt = hold == '0 ? IDLE : HOLD;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      pop = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= in_word;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) dec_word <= '0;
    else if (pop) dec_word <= mem[rd_ptr];
  end
  // Entering HOLD loads HOLD_CYCLES-1 so the window spans exactly HOLD_CYCLES cycles
  always_ff @(posedge clk) begin
    if (rst || flush) hold <= '0;
    else if (state == ISSUE && state_nxt == HOLD) hold <= HW'(HOLD_CYCLES-1);
    else if (state == HOLD && hold != '0) hold <= hold - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) issued_cnt <= '0;
    else if (dec_valid && dec_ack) issued_cnt <= issued_cnt + 1'b1;
  end
endmodule
